// File: rtl/latency_mem_pkg.sv
// Shared types and constants for the fixed-latency word memory.
package latency_mem_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [15:0] ErrBoth   = 16'h0001;
  localparam logic [15:0] ErrAlign  = 16'h0002;
  localparam logic [15:0] ErrRange  = 16'h0004;
  localparam logic [15:0] ErrChange = 16'h0008;

  // Any of these at capture blocks the write commit.
  localparam logic [15:0] ErrNoWrite = ErrBoth | ErrAlign | ErrRange;

  localparam logic [31:0] NopWord = 32'h0000_0013;

  // Errors detectable from the request as presented at the capture edge.
  function automatic logic [15:0] capture_err(input logic        rd,
                                              input logic        wr,
                                              input logic [31:0] addr,
                                              input logic [32:0] limit);
    logic [15:0] err;
    err = '0;
    if (rd && wr) err = err | ErrBoth;
    if (addr[1:0] != 2'b00) err = err | ErrAlign;
    if ({1'b0, addr} >= limit) err = err | ErrRange;
    return err;
  endfunction

endpackage

// File: rtl/latency_mem_array.sv
// Depth x 32 word store with byte-lane writes; unwritten words read as NopWord.
module latency_mem_array
  import latency_mem_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned Aw    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [Aw-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0]      mem_q [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [31:0]      merged;

  always_comb begin
    rdata_o = valid_q[addr_i] ? mem_q[addr_i] : NopWord;
  end

  // Untouched lanes come from the current read-back, so invalid words merge into NopWord.
  always_comb begin
    merged = rdata_o;
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (we_i) valid_d[addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= merged;
  end

endmodule

// File: rtl/latency_mem.sv
// Single-outstanding memory responder with fixed capture-to-response latency
// and sticky protocol-error reporting.
module latency_mem
  import latency_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic [15:0] errcode
);

  localparam int unsigned Aw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] AddrLimit = 33'(DEPTH) << 2;
  localparam logic [3:0]  CntInit   = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        wr_ok_q, wr_ok_d;
  logic        rd_oor_q, rd_oor_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] errcode_q, errcode_d;

  logic [15:0] cap_err;
  logic        live_differs;
  logic        arr_we;
  logic [31:0] arr_rdata;

  assign cap_err      = capture_err(mem_read, mem_write, mem_address, AddrLimit);
  assign live_differs = {mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata} !=
                        {rd_q, wr_q, be_q, addr_q, wdata_q};
  // Commit happens on the edge that leaves RESP back to IDLE.
  assign arr_we       = (state_q == StResp) && wr_q && wr_ok_q;

  latency_mem_array #(
    .Depth (DEPTH),
    .Aw    (Aw)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .addr_i  (addr_q[Aw+1:2]),
    .we_i    (arr_we),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    wr_ok_d   = wr_ok_q;
    rd_oor_d  = rd_oor_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    resp_d    = 1'b0;
    rdata_d   = rdata_q;
    errcode_d = errcode_q;

    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          rd_d      = mem_read;
          wr_d      = mem_write;
          wr_ok_d   = (cap_err & ErrNoWrite) == '0;
          rd_oor_d  = (cap_err & ErrRange) != '0;
          addr_d    = mem_address;
          be_d      = mem_byte_enable;
          wdata_d   = mem_wdata;
          cnt_d     = CntInit;
          errcode_d = errcode_q | cap_err;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (live_differs) errcode_d = errcode_d | ErrChange;
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          resp_d  = 1'b1;
          if (rd_q) rdata_d = rd_oor_q ? NopWord : arr_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wr_ok_q   <= 1'b0;
      rd_oor_q  <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      resp_q    <= 1'b0;
      rdata_q   <= NopWord;
      errcode_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wr_ok_q   <= wr_ok_d;
      rd_oor_q  <= rd_oor_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      errcode_q <= errcode_d;
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign errcode   = errcode_q;
  assign mem_error = |errcode_q;

endmodule
